// File: rtl/axi_pkg.sv
// Shared AXI encodings and the responder FSM state type.
//   burst_e : FIXED / INCR / WRAP burst encodings (2'b11 is handled as INCR by users)
//   RESP_*  : AXI response codes
//   state_e : axi_mem_responder controller states
package axi_pkg;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10
   } burst_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_DATA,
      S_WR_RESP,
      S_RD_BURST,
      S_RD_DRAIN
   } state_e;

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational AXI next-beat address calculator.
//   addr      in  current beat byte address
//   len       in  burst length minus one
//   size      in  log2 of bytes per beat
//   burst     in  burst type (FIXED/INCR/WRAP, reserved encoding treated as INCR)
//   next_addr out byte address of the following beat
module axi_burst_addr
   import axi_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
)(
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [7:0]            len,
   input  logic [2:0]            size,
   input  logic [1:0]            burst,
   output logic [ADDR_WIDTH-1:0] next_addr
);

   logic [ADDR_WIDTH-1:0] step;
   logic [ADDR_WIDTH-1:0] wrap_mask;
   logic [ADDR_WIDTH-1:0] incr_addr;

   always_comb begin
      step      = ADDR_WIDTH'(1) << size;
      // Legal WRAP lengths give a power-of-two container, so the mask keeps the
      // in-container offset and the incremented offset rolls over to the base.
      wrap_mask = (ADDR_WIDTH'({1'b0, len} + 9'd1) << size) - ADDR_WIDTH'(1);
      incr_addr = addr + step;
      case (burst)
         BURST_FIXED: next_addr = addr;
         BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
         default:     next_addr = incr_addr;
      endcase
   end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave terminating one outstanding burst at a time onto a single-port
// synchronous BRAM (read data one cycle after mem_en).
//   clk, rst          single clock, synchronous active-high reset
//   s_axi_aw*/w*/b*   write address / data / response channels
//   s_axi_ar*/r*      read address / data channels
//   mem_en/we/addr/wdata, mem_rdata   BRAM port (mem_we==0 means read)
// Optional build macro AXI_MEM_RESPONDER_DECERR_EN: beats outside the mapped
// window skip the BRAM and answer DECERR; otherwise addresses alias.
//
// state      | meaning
// S_IDLE     | arbitrate AW/AR, alternate grants under contention
// S_WR_DATA  | accept W beats, write each into BRAM
// S_WR_RESP  | hold B until bready
// S_RD_BURST | issue BRAM reads while the 2-entry R buffer has room
// S_RD_DRAIN | all reads issued, wait for the rlast handshake
module axi_mem_responder
   import axi_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 64,
   parameter int                    ID_WIDTH   = 8,
   parameter int                    MEM_AW     = 14,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    s_axi_awvalid,
   output logic                    s_axi_awready,
   input  logic [ID_WIDTH-1:0]     s_axi_awid,
   input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic [7:0]              s_axi_awlen,
   input  logic [2:0]              s_axi_awsize,
   input  logic [1:0]              s_axi_awburst,
   input  logic                    s_axi_wvalid,
   output logic                    s_axi_wready,
   input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic                    s_axi_wlast,
   output logic                    s_axi_bvalid,
   input  logic                    s_axi_bready,
   output logic [ID_WIDTH-1:0]     s_axi_bid,
   output logic [1:0]              s_axi_bresp,
   input  logic                    s_axi_arvalid,
   output logic                    s_axi_arready,
   input  logic [ID_WIDTH-1:0]     s_axi_arid,
   input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic [7:0]              s_axi_arlen,
   input  logic [2:0]              s_axi_arsize,
   input  logic [1:0]              s_axi_arburst,
   output logic                    s_axi_rvalid,
   input  logic                    s_axi_rready,
   output logic [ID_WIDTH-1:0]     s_axi_rid,
   output logic [DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [1:0]              s_axi_rresp,
   output logic                    s_axi_rlast,
   output logic                    mem_en,
   output logic [DATA_WIDTH/8-1:0] mem_we,
   output logic [MEM_AW-1:0]       mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic [DATA_WIDTH-1:0]   mem_rdata
);

   localparam int SHIFT = $clog2(DATA_WIDTH/8);
`ifdef AXI_MEM_RESPONDER_DECERR_EN
   localparam bit DEC_EN = 1'b1;
`else
   localparam bit DEC_EN = 1'b0;
`endif

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [1:0]            resp;
      logic                  last;
   } rbeat_t;

   state_e                state;
   logic [ID_WIDTH-1:0]   id_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [7:0]            len_q;
   logic [2:0]            size_q;
   logic [1:0]            burst_q;
   logic [7:0]            cnt_q;
   logic                  slverr_q, decerr_q, prio_wr_q;
   logic                  infl_q, infl_dec_q, infl_last_q;
   rbeat_t                fifo0, fifo1, new_beat;
   logic [1:0]            fcnt;

   logic [ADDR_WIDTH-1:0] next_addr, off_word;
   logic                  dec_beat, grant_wr, grant_rd, pop, issue, final_beat;
   logic [2:0]            occ;

   axi_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_burst_addr (
      .addr      (addr_q),
      .len       (len_q),
      .size      (size_q),
      .burst     (burst_q),
      .next_addr (next_addr)
   );

   assign off_word   = (addr_q - BASE_ADDR) >> SHIFT;
   assign dec_beat   = DEC_EN && (|off_word[ADDR_WIDTH-1:MEM_AW]);
   assign final_beat = (cnt_q == len_q);

   assign s_axi_bvalid = (state == S_WR_RESP);
   assign s_axi_bid    = id_q;
   assign s_axi_bresp  = decerr_q ? RESP_DECERR : (slverr_q ? RESP_SLVERR : RESP_OKAY);
   assign s_axi_rvalid = (fcnt != 2'd0);
   assign s_axi_rid    = id_q;
   assign s_axi_rdata  = fifo0.data;
   assign s_axi_rresp  = fifo0.resp;
   assign s_axi_rlast  = fifo0.last;

   assign pop = s_axi_rvalid && s_axi_rready;
   // A beat leaving this cycle frees its slot, which keeps reads at 1 beat/cycle.
   assign occ   = {1'b0, fcnt} + {2'b00, infl_q} - {2'b00, pop};
   assign issue = (state == S_RD_BURST) && (occ < 3'd2);

   assign new_beat.data = infl_dec_q ? '0 : mem_rdata;
   assign new_beat.resp = infl_dec_q ? RESP_DECERR : RESP_OKAY;
   assign new_beat.last = infl_last_q;

   always_comb begin
      grant_wr      = s_axi_awvalid && (prio_wr_q || !s_axi_arvalid);
      grant_rd      = s_axi_arvalid && !grant_wr;
      s_axi_awready = 1'b0;
      s_axi_arready = 1'b0;
      s_axi_wready  = 1'b0;
      mem_en        = 1'b0;
      mem_we        = '0;
      mem_addr      = off_word[MEM_AW-1:0];
      mem_wdata     = s_axi_wdata;
      case (state)
         S_IDLE: begin
            s_axi_awready = grant_wr;
            s_axi_arready = grant_rd;
         end
         S_WR_DATA: begin
            s_axi_wready = 1'b1;
            if (s_axi_wvalid && !dec_beat) begin
               mem_en = 1'b1;
               mem_we = s_axi_wstrb;
            end
         end
         S_RD_BURST: mem_en = issue && !dec_beat;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         id_q        <= '0;
         addr_q      <= '0;
         len_q       <= '0;
         size_q      <= '0;
         burst_q     <= '0;
         cnt_q       <= '0;
         slverr_q    <= 1'b0;
         decerr_q    <= 1'b0;
         prio_wr_q   <= 1'b1;
         infl_q      <= 1'b0;
         infl_dec_q  <= 1'b0;
         infl_last_q <= 1'b0;
         fifo0       <= '0;
         fifo1       <= '0;
         fcnt        <= '0;
      end else begin
         infl_q      <= issue;
         infl_dec_q  <= dec_beat;
         infl_last_q <= final_beat;

         case ({infl_q, pop})
            2'b10: begin
               if (fcnt == 2'd0) fifo0 <= new_beat;
               else              fifo1 <= new_beat;
               fcnt <= fcnt + 2'd1;
            end
            2'b01: begin
               fifo0 <= fifo1;
               fcnt  <= fcnt - 2'd1;
            end
            2'b11: begin
               if (fcnt == 2'd1) begin
                  fifo0 <= new_beat;
               end else begin
                  fifo0 <= fifo1;
                  fifo1 <= new_beat;
               end
            end
            default: ;
         endcase

         case (state)
            S_IDLE: begin
               if (s_axi_awready) begin
                  id_q      <= s_axi_awid;
                  addr_q    <= s_axi_awaddr;
                  len_q     <= s_axi_awlen;
                  size_q    <= s_axi_awsize;
                  burst_q   <= s_axi_awburst;
                  cnt_q     <= '0;
                  slverr_q  <= 1'b0;
                  decerr_q  <= 1'b0;
                  prio_wr_q <= 1'b0;
                  state     <= S_WR_DATA;
               end else if (s_axi_arready) begin
                  id_q      <= s_axi_arid;
                  addr_q    <= s_axi_araddr;
                  len_q     <= s_axi_arlen;
                  size_q    <= s_axi_arsize;
                  burst_q   <= s_axi_arburst;
                  cnt_q     <= '0;
                  prio_wr_q <= 1'b1;
                  state     <= S_RD_BURST;
               end
            end
            S_WR_DATA: begin
               if (s_axi_wvalid) begin
                  addr_q <= next_addr;
                  cnt_q  <= cnt_q + 8'd1;
                  if (s_axi_wlast != final_beat) slverr_q <= 1'b1;
                  if (dec_beat)                  decerr_q <= 1'b1;
                  if (final_beat)                state    <= S_WR_RESP;
               end
            end
            S_WR_RESP: if (s_axi_bready) state <= S_IDLE;
            S_RD_BURST: begin
               if (issue) begin
                  addr_q <= next_addr;
                  cnt_q  <= cnt_q + 8'd1;
                  if (final_beat) state <= S_RD_DRAIN;
               end
            end
            S_RD_DRAIN: if (pop && fifo0.last) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_mem_responder.sv
module tb_axi_mem_responder;
   import axi_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
   logic        arvalid, arready, rvalid, rready, rlast;
   logic [7:0]  awid, awlen, arid, arlen, bid, rid, wstrb, mem_we;
   logic [31:0] awaddr, araddr;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, arburst, bresp, rresp;
   logic [63:0] wdata, rdata, mem_wdata, mem_rdata;
   logic        mem_en;
   logic [13:0] mem_addr;

   logic [63:0] mem [0:16383];
   int          checks = 0;
   int          failures = 0;
   int          mem_en_cnt = 0;
   bit          rr_rand = 1'b0;

   typedef struct {logic [63:0] data; logic [1:0] resp; logic last; logic [7:0] id;} rexp_t;
   typedef struct {logic [7:0] id; logic [1:0] resp;} bexp_t;
   rexp_t exp_r[$];
   bexp_t exp_b[$];

   always #5 clk = ~clk;

   axi_mem_responder dut (
      .clk(clk), .rst(rst),
      .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awid(awid), .s_axi_awaddr(awaddr),
      .s_axi_awlen(awlen), .s_axi_awsize(awsize), .s_axi_awburst(awburst),
      .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
      .s_axi_wlast(wlast),
      .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bid(bid), .s_axi_bresp(bresp),
      .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_arid(arid), .s_axi_araddr(araddr),
      .s_axi_arlen(arlen), .s_axi_arsize(arsize), .s_axi_arburst(arburst),
      .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rid(rid), .s_axi_rdata(rdata),
      .s_axi_rresp(rresp), .s_axi_rlast(rlast),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // Behavioural single-port BRAM with one-cycle read latency.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we == 8'h00) mem_rdata <= mem[mem_addr];
         else
            for (int i = 0; i < 8; i++)
               if (mem_we[i]) mem[mem_addr][i*8 +: 8] <= mem_wdata[i*8 +: 8];
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      failures++;
      $display("FAIL %s: actual=timeout required=handshake", name);
   endtask

   task automatic push_r(input logic [63:0] d, input logic [1:0] r, input logic l, input logic [7:0] id);
      rexp_t e;
      e.data = d; e.resp = r; e.last = l; e.id = id;
      exp_r.push_back(e);
   endtask

   task automatic push_b(input logic [7:0] id, input logic [1:0] r);
      bexp_t e;
      e.id = id; e.resp = r;
      exp_b.push_back(e);
   endtask

   // R scoreboard monitor and stall-stability check.
   rexp_t       re;
   bit          stall_prev = 1'b0;
   logic [63:0] st_data;
   logic        st_last;
   always @(negedge clk) begin
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            chk("r_stall_valid", {63'd0, rvalid}, 64'd1);
            chk("r_stall_data", rdata, st_data);
            chk("r_stall_last", {63'd0, rlast}, {63'd0, st_last});
         end
         stall_prev = rvalid && !rready;
         st_data    = rdata;
         st_last    = rlast;
         if (rvalid && rready) begin
            if (exp_r.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL r_unexpected: actual=beat 0x%0h required=no beat", rdata);
            end else begin
               re = exp_r.pop_front();
               chk("r_data", rdata, re.data);
               chk("r_resp", {62'd0, rresp}, {62'd0, re.resp});
               chk("r_last", {63'd0, rlast}, {63'd0, re.last});
               chk("r_id", {56'd0, rid}, {56'd0, re.id});
            end
         end
      end
   end

   // B scoreboard monitor.
   bexp_t be;
   always @(negedge clk) begin
      if (!rst && bvalid && bready) begin
         if (exp_b.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL b_unexpected: actual=resp %0d required=no response", bresp);
         end else begin
            be = exp_b.pop_front();
            chk("b_id", {56'd0, bid}, {56'd0, be.id});
            chk("b_resp", {62'd0, bresp}, {62'd0, be.resp});
         end
      end
   end

   always @(negedge clk) if (mem_en) mem_en_cnt++;

   initial forever begin
      @(posedge clk);
      #1;
      rready = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic aw_send(input logic [7:0] id, input logic [31:0] a, input logic [7:0] l,
                          input logic [1:0] b);
      logic hs = 1'b0;
      @(posedge clk); #1;
      awvalid = 1'b1; awid = id; awaddr = a; awlen = l; awsize = 3'd3; awburst = b;
      for (int i = 0; i < 100 && !hs; i++) begin @(negedge clk); hs = awready; end
      if (!hs) timeout("aw_handshake");
      @(posedge clk); #1;
      awvalid = 1'b0;
   endtask

   task automatic ar_send(input logic [7:0] id, input logic [31:0] a, input logic [7:0] l,
                          input logic [1:0] b);
      logic hs = 1'b0;
      @(posedge clk); #1;
      arvalid = 1'b1; arid = id; araddr = a; arlen = l; arsize = 3'd3; arburst = b;
      for (int i = 0; i < 100 && !hs; i++) begin @(negedge clk); hs = arready; end
      if (!hs) timeout("ar_handshake");
      @(posedge clk); #1;
      arvalid = 1'b0;
   endtask

   task automatic w_send(input logic [63:0] d, input logic [7:0] s, input logic l);
      logic hs = 1'b0;
      @(posedge clk); #1;
      wvalid = 1'b1; wdata = d; wstrb = s; wlast = l;
      for (int i = 0; i < 100 && !hs; i++) begin @(negedge clk); hs = wready; end
      if (!hs) timeout("w_handshake");
      @(posedge clk); #1;
      wvalid = 1'b0; wlast = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         done = (exp_r.size() == 0) && (exp_b.size() == 0);
      end
      if (!done) timeout(name);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=still running required=finished");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int  lat;
      bit  found;
      int  en0;
      for (int i = 0; i < 16384; i++) mem[i] = 64'd0;
      rst = 1'b1; bready = 1'b1;
      awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
      arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0;
      wvalid = 0; wdata = 0; wstrb = 0; wlast = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_awready", {63'd0, awready}, 64'd0);
      chk("rst_arready", {63'd0, arready}, 64'd0);
      chk("rst_wready", {63'd0, wready}, 64'd0);
      chk("rst_bvalid", {63'd0, bvalid}, 64'd0);
      chk("rst_rvalid", {63'd0, rvalid}, 64'd0);
      chk("rst_mem_en", {63'd0, mem_en}, 64'd0);
      chk("rst_mem_we", {56'd0, mem_we}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Contention #1: write wins first after reset; INCR write len=3.
      push_b(8'h5A, RESP_OKAY);
      @(posedge clk); #1;
      awvalid = 1; awid = 8'h5A; awaddr = 32'h8000_0000; awlen = 8'd3; awsize = 3'd3; awburst = BURST_INCR;
      arvalid = 1; arid = 8'h33; araddr = 32'h8000_0000; arlen = 8'd3; arsize = 3'd3; arburst = BURST_INCR;
      @(negedge clk);
      chk("grant1_awready", {63'd0, awready}, 64'd1);
      chk("grant1_arready", {63'd0, arready}, 64'd0);
      @(posedge clk); #1;
      awvalid = 0; arvalid = 0;
      w_send(64'h11, 8'hFF, 1'b0);
      w_send(64'h22, 8'hFF, 1'b0);
      w_send(64'h33, 8'hFF, 1'b0);
      w_send(64'h44, 8'hFF, 1'b1);
      wait_done("write_incr_done");
      chk("mem_w0", mem[0], 64'h11);
      chk("mem_w1", mem[1], 64'h22);
      chk("mem_w2", mem[2], 64'h33);
      chk("mem_w3", mem[3], 64'h44);

      // Contention #2: read wins; read back with rready held high.
      push_r(64'h11, RESP_OKAY, 1'b0, 8'h33);
      push_r(64'h22, RESP_OKAY, 1'b0, 8'h33);
      push_r(64'h33, RESP_OKAY, 1'b0, 8'h33);
      push_r(64'h44, RESP_OKAY, 1'b1, 8'h33);
      @(posedge clk); #1;
      awvalid = 1; arvalid = 1;
      @(negedge clk);
      chk("grant2_arready", {63'd0, arready}, 64'd1);
      chk("grant2_awready", {63'd0, awready}, 64'd0);
      @(posedge clk); #1;
      awvalid = 0; arvalid = 0;
      lat = 0; found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (rvalid) found = 1;
         else lat++;
      end
      chk("rd_first_latency", 64'(lat), 64'd2);
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         chk("rd_back_to_back", {63'd0, rvalid}, 64'd1);
      end
      wait_done("read_incr_done");

      // WRAP read from word 2 with random rready stalls: order 2,3,0,1.
      rr_rand = 1'b1;
      push_r(64'h33, RESP_OKAY, 1'b0, 8'h21);
      push_r(64'h44, RESP_OKAY, 1'b0, 8'h21);
      push_r(64'h11, RESP_OKAY, 1'b0, 8'h21);
      push_r(64'h22, RESP_OKAY, 1'b1, 8'h21);
      ar_send(8'h21, 32'h8000_0010, 8'd3, BURST_WRAP);
      wait_done("read_wrap_done");
      rr_rand = 1'b0;

      // wlast on beat 0 of a 2-beat burst: SLVERR, both beats still written.
      push_b(8'h07, RESP_SLVERR);
      aw_send(8'h07, 32'h8000_0040, 8'd1, BURST_INCR);
      w_send(64'hA1, 8'hFF, 1'b1);
      w_send(64'hA2, 8'hFF, 1'b0);
      wait_done("write_slverr_done");
      chk("mem_w8", mem[8], 64'hA1);
      chk("mem_w9", mem[9], 64'hA2);

      // FIXED burst with partial strobe on the second beat.
      push_b(8'h08, RESP_OKAY);
      aw_send(8'h08, 32'h8000_0080, 8'd1, BURST_FIXED);
      w_send(64'h1111_2222_3333_4444, 8'hFF, 1'b0);
      w_send(64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, 1'b1);
      wait_done("write_fixed_done");
      chk("mem_w16", mem[16], 64'h1111_2222_CCCC_DDDD);
      chk("mem_w17", mem[17], 64'h0);

`ifdef AXI_MEM_RESPONDER_DECERR_EN
      en0 = mem_en_cnt;
      push_b(8'h09, RESP_DECERR);
      aw_send(8'h09, 32'h9000_0000, 8'd0, BURST_INCR);
      w_send(64'hDEAD, 8'hFF, 1'b1);
      wait_done("write_decerr_done");
      chk("decerr_wr_mem_en", 64'(mem_en_cnt - en0), 64'd0);
      push_r(64'h0, RESP_DECERR, 1'b1, 8'h0A);
      ar_send(8'h0A, 32'h9000_0000, 8'd0, BURST_INCR);
      wait_done("read_decerr_done");
`else
      en0 = mem_en_cnt;
`endif

      // Reset in the middle of an 8-beat read, after beat 1 completes.
      push_r(64'h11, RESP_OKAY, 1'b0, 8'h44);
      push_r(64'h22, RESP_OKAY, 1'b0, 8'h44);
      push_r(64'h33, RESP_OKAY, 1'b0, 8'h44);
      push_r(64'h44, RESP_OKAY, 1'b0, 8'h44);
      for (int k = 0; k < 3; k++) push_r(64'h0, RESP_OKAY, 1'b0, 8'h44);
      push_r(64'h0, RESP_OKAY, 1'b1, 8'h44);
      ar_send(8'h44, 32'h8000_0000, 8'd7, BURST_INCR);
      found = 0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clk);
         found = (exp_r.size() <= 6);
      end
      if (!found) timeout("reset_mid_burst_wait");
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_r.delete();
      @(negedge clk);
      chk("post_rst_rvalid", {63'd0, rvalid}, 64'd0);
      chk("post_rst_awready", {63'd0, awready}, 64'd0);
      chk("post_rst_arready", {63'd0, arready}, 64'd0);
      push_r(64'hA1, RESP_OKAY, 1'b0, 8'h55);
      push_r(64'hA2, RESP_OKAY, 1'b1, 8'h55);
      @(posedge clk); #1;
      arvalid = 1; arid = 8'h55; araddr = 32'h8000_0040; arlen = 8'd1; arsize = 3'd3; arburst = BURST_INCR;
      @(negedge clk);
      chk("post_rst_ar_grant", {63'd0, arready}, 64'd1);
      chk("post_rst_aw_grant", {63'd0, awready}, 64'd0);
      @(posedge clk); #1;
      arvalid = 0;
      wait_done("post_rst_read_done");

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axi_mem_responder.md
Name: axi_mem_responder

Overview:
- AXI4 slave (responder) terminating a core-side AXI memory master (64-bit data, 8-bit ID) onto a single-port synchronous BRAM.
- Used as on-chip memory/boot RAM when running the core without the SoC DDR path, and as the memory model in block-level simulation.
- One outstanding transaction at a time. Full INCR/WRAP/FIXED burst support. Pipelined read data at 1 beat/cycle.

Parameters:
- ADDR_WIDTH, 32, AXI byte address width.
- DATA_WIDTH, 64, AXI data width; mem word = DATA_WIDTH bits.
- ID_WIDTH, 8, AXI ID width.
- MEM_AW, 14, BRAM word-address width (2^14 x 64b = 128 KiB).
- BASE_ADDR, 32'h8000_0000, byte address mapped to mem word 0.

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- s_axi_aw{valid,ready,id,addr,len,size,burst}  in/out  1,1,ID_WIDTH,ADDR_WIDTH,8,3,2  write address channel
- s_axi_w{valid,ready,data,strb,last}  in/out  1,1,DATA_WIDTH,DATA_WIDTH/8,1  write data channel
- s_axi_b{valid,ready,id,resp}  out/in  1,1,ID_WIDTH,2  write response channel
- s_axi_ar{valid,ready,id,addr,len,size,burst}  in/out  as AW  read address channel
- s_axi_r{valid,ready,id,data,resp,last}  out/in  1,1,ID_WIDTH,DATA_WIDTH,2,1  read data channel
- mem_en  out  1  BRAM access enable
- mem_we  out  DATA_WIDTH/8  byte write enables (0 = read)
- mem_addr  out  MEM_AW  word address
- mem_wdata  out  DATA_WIDTH  write data
- mem_rdata  in  DATA_WIDTH  read data, valid 1 cycle after mem_en with mem_we==0

Behaviour:
- Reset: all ready/valid outputs 0, mem_en=0, mem_we=0, FSM=IDLE, read buffer empty, priority=write. Reset mid-burst aborts silently: no B/R completion, and beats already written remain in memory.
- FSM states: IDLE, WR_DATA, WR_RESP, RD_BURST, RD_DRAIN.
- IDLE: awready/arready driven combinationally from state and priority. Only one of them is asserted per cycle.
  - Both AW and AR valid: grant the side opposite to the last grant. First grant after reset goes to write.
  - Accept latches id/addr/len/size/burst and clears beat counter.
  - Transitions: AW -> WR_DATA; AR -> RD_BURST.
- Address generation (per beat): word addr = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8), truncated to MEM_AW.
  - INCR: addr += 1<<size.
  - FIXED: addr unchanged.
  - WRAP: container = (len+1)<<size, aligned down. Addr increments and wraps to the container base at the container top.
  - burst=2'b11 is treated as INCR.
- WR_DATA: wready=1.
  - Each w handshake drives mem_en=1, mem_we=wstrb, mem_wdata=wdata, then advances addr and counter.
  - When counter==len, goto WR_RESP.
  - wlast mismatch (wlast on a non-final beat, or missing on the final beat) sets bresp=SLVERR; the burst still completes on counter==len.
- WR_RESP: bvalid=1, bid=latched id, bresp=OKAY unless an error was flagged. bvalid is held until bready; then IDLE.
- RD_BURST: issue mem read (mem_en=1, mem_we=0) whenever buffered+inflight < 2 and beats remain.
  - Data returned next cycle enters a 2-entry FIFO feeding R.
  - rvalid = FIFO not empty; rid=latched id; rresp=OKAY; rlast asserted on beat index len.
  - With rready held high: first rvalid 2 cycles after the AR handshake, then 1 beat/cycle.
  - R outputs stable while rvalid && !rready.
  - After the last issue, goto RD_DRAIN. Leave RD_DRAIN for IDLE on the rlast handshake.
- len=0: single beat, rlast/final-beat rules apply on beat 0.
- No AW/AR is accepted until the current transaction fully completes, including the B or final R handshake.

Optional Feature:
- Macro AXI_MEM_RESPONDER_DECERR_EN.
- Defined:
  - Any beat whose byte address lies outside [BASE_ADDR, BASE_ADDR + 2^MEM_AW*DATA_WIDTH/8) suppresses mem_en for that beat.
  - Write: bresp=DECERR, which takes precedence over SLVERR.
  - Read: that beat returns rdata=0 and rresp=DECERR, while keeping its slot in the FIFO order.
- Undefined: addresses are simply truncated to MEM_AW (aliasing) and no DECERR is ever produced.

Decomposition:
- Package axi_pkg: burst encodings (FIXED/INCR/WRAP), resp encodings (OKAY/EXOKAY/SLVERR/DECERR), FSM state enum.
- Sub-module axi_burst_addr: combinational next-address calculator (addr, len, size, burst -> next addr). It is shared by the read and write paths and reusable by other AXI slaves.

Test Plan:
- Write INCR, awaddr=0x8000_0000, len=3, strb=0xFF, data 0x11..0x44 -> bresp=OKAY, bid echoed; mem words 0..3 hold 0x11..0x44.
- Read the same burst with rready=1 -> rvalid 2 cycles after AR, 4 consecutive beats 0x11..0x44, rlast only on beat 3.
- Read WRAP len=3 at 0x8000_0010 with random rready stalls -> word order 2,3,0,1; no beat lost or duplicated; R stable during stalls.
- AW and AR valid in the same cycle twice in a row -> first grant write, second grant read.
- Write len=1 with wlast on beat 0 -> bresp=SLVERR, both beats written. With DECERR_EN: write to 0x9000_0000 -> bresp=DECERR, mem_en never asserted.
- Assert rst mid read burst (after beat 1 of len=7) -> next cycle rvalid=0, arready/awready follow IDLE rules, and a new read returns correct data.
